flag_condition_unit: RTL and testbench

- Consumes ALU results and NZCV flags (N, Z, C, V); holds the architectural flags register; evaluates a 4-bit condition code per operation.
- Sits downstream of the ALU: each ALU output plus its condition, set-flags bit and destination enters through a valid/ready handshake.
- Emits an ordered writeback stream in which each op is tagged execute or squash.
- Flags commit in program order, so back-to-back conditional ops need no stall.

---
 rtl/cond_pkg.sv | 33 +++
 rtl/cond_check.sv | 33 +++
 rtl/flag_condition_unit.sv | 120 ++++++++++++
 tb/tb_flag_condition_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types for the flag/condition unit: condition codes, NZCV flags
// and writeback buffer depth.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator against an NZCV flag set.
module cond_check
  import cond_pkg::*;
(
  input  flags_t f,
  input  cond_e  cond,
  output logic   pass
);

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      EQ: pass = f.z;
      NE: pass = !f.z;
      CS: pass = f.c;
      CC: pass = !f.c;
      MI: pass = f.n;
      PL: pass = !f.n;
      VS: pass = f.v;
      VC: pass = !f.v;
      HI: pass = f.c && !f.z;
      LS: pass = !f.c || f.z;
      GE: pass = (f.n == f.v);
      LT: pass = (f.n != f.v);
      GT: pass = !f.z && (f.n == f.v);
      LE: pass = f.z || (f.n != f.v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_condition_unit.sv
// Architectural NZCV flags, condition evaluation and 2-entry writeback FIFO.
// Optional FLAG_COND_STATS_EN adds saturating exec/squash counters.
module flag_condition_unit
  import cond_pkg::*;
#(
  parameter int N      = 4,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_result,
  input  logic [3:0]        in_flags,
  input  logic [3:0]        in_cond,
  input  logic              in_set_flags,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_write,
  output logic [3:0]        flags
`ifdef FLAG_COND_STATS_EN
  ,
  output logic [15:0]       exec_count,
  output logic [15:0]       squash_count
`endif
);

  flags_t            flags_q;
  logic              pass;
  logic              push;
  logic              pop;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [N-1:0]      mem_result [FIFO_DEPTH];
  logic [DEST_W-1:0] mem_dest   [FIFO_DEPTH];
  logic              mem_write  [FIFO_DEPTH];
  logic [N-1:0]      last_result;
  logic [DEST_W-1:0] last_dest;
  logic              last_write;

  cond_check u_cond_check (
    .f    (flags_q),
    .cond (cond_e'(in_cond)),
    .pass (pass)
  );

  assign in_ready  = (count != 2'(FIFO_DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign flags     = flags_q;

  // When empty, show the last popped entry so outputs stay stable.
  always_comb begin
    out_result = last_result;
    out_dest   = last_dest;
    out_write  = last_write;
    if (out_valid) begin
      out_result = mem_result[rd_ptr];
      out_dest   = mem_dest[rd_ptr];
      out_write  = mem_write[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      last_result <= '0;
      last_dest   <= '0;
      last_write  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_result[i] <= '0;
        mem_dest[i]   <= '0;
        mem_write[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_result[wr_ptr] <= in_result;
        mem_dest[wr_ptr]   <= in_dest;
        mem_write[wr_ptr]  <= pass;
        wr_ptr             <= wr_ptr + 1'b1;
        if (pass && in_set_flags)
          flags_q <= flags_t'(in_flags);
      end
      if (pop) begin
        last_result <= mem_result[rd_ptr];
        last_dest   <= mem_dest[rd_ptr];
        last_write  <= mem_write[rd_ptr];
        rd_ptr      <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef FLAG_COND_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_count   <= 16'd0;
      squash_count <= 16'd0;
    end else if (push) begin
      if (pass && exec_count != 16'hFFFF)
        exec_count <= exec_count + 16'd1;
      if (!pass && squash_count != 16'hFFFF)
        squash_count <= squash_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flag_condition_unit.sv
// Directed self-checking bench for flag_condition_unit.
module tb_flag_condition_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic [3:0] in_flags;
  logic [3:0] in_cond;
  logic       in_set_flags;
  logic [3:0] in_dest;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_dest;
  logic       out_write;
  logic [3:0] flags;
`ifdef FLAG_COND_STATS_EN
  logic [15:0] exec_count;
  logic [15:0] squash_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flag_condition_unit #(.N(4), .DEST_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_cond      (in_cond),
    .in_set_flags (in_set_flags),
    .in_dest      (in_dest),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_dest     (out_dest),
    .out_write    (out_write),
    .flags        (flags)
`ifdef FLAG_COND_STATS_EN
    ,
    .exec_count   (exec_count),
    .squash_count (squash_count)
`endif
  );

  // Hand table of condition results; f = {N,Z,C,V}.
  function automatic logic exp_pass(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return cy;
      4'd3:  return ~cy;
      4'd4:  return n;
      4'd5:  return ~n;
      4'd6:  return v;
      4'd7:  return ~v;
      4'd8:  return cy & ~z;
      4'd9:  return ~cy | z;
      4'd10: return ~(n ^ v);
      4'd11: return n ^ v;
      4'd12: return ~z & ~(n ^ v);
      4'd13: return z | (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] res, input logic [3:0] fl,
                       input logic [3:0] cond, input logic set,
                       input logic [3:0] dest);
    @(negedge clk);
    in_valid     = 1'b1;
    in_result    = res;
    in_flags     = fl;
    in_cond      = cond;
    in_set_flags = set;
    in_dest      = dest;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (flags !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", flags);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    total++;
    if (out_result !== 4'h0 || out_dest !== 4'h0 || out_write !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got=%h/%h/%b want=0/0/0",
               out_result, out_dest, out_write);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(4'h0, 4'b0100, 4'b1110, 1'b1, 4'h1);
    total++;
    if (out_valid !== 1'b1 || out_write !== 1'b1 || out_dest !== 4'h1) begin
      bad++;
      $display("FAIL b2b_first got=v%b w%b d%h want=v1 w1 d1",
               out_valid, out_write, out_dest);
    end
    total++;
    if (flags !== 4'b0100) begin
      bad++; $display("FAIL b2b_flags got=%b want=0100", flags);
    end
    drive(4'h7, 4'b0000, 4'b0000, 1'b0, 4'h2);
    total++;
    if (out_write !== 1'b1 || out_result !== 4'h7 || out_dest !== 4'h2) begin
      bad++;
      $display("FAIL b2b_second got=w%b r%h d%h want=w1 r7 d2",
               out_write, out_result, out_dest);
    end
  endtask

  task automatic test_squash();
    drive(4'h3, 4'b1000, 4'b0001, 1'b1, 4'h3);
    total++;
    if (out_valid !== 1'b1 || out_write !== 1'b0 || out_result !== 4'h3) begin
      bad++;
      $display("FAIL squash_out got=v%b w%b r%h want=v1 w0 r3",
               out_valid, out_write, out_result);
    end
    total++;
    if (flags !== 4'b0100) begin
      bad++; $display("FAIL squash_flags got=%b want=0100", flags);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_empty got=%b want=0", out_valid);
    end
  endtask

  task automatic test_sweep();
    out_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      drive(4'(f), 4'(f), 4'b1110, 1'b1, 4'h0);
      total++;
      if (flags !== 4'(f)) begin
        bad++; $display("FAIL sweep_setflags got=%b want=%b", flags, 4'(f));
      end
      for (int c = 0; c < 16; c++) begin
        drive(4'(c), 4'hF, 4'(c), 1'b0, 4'h5);
        total++;
        if (out_write !== exp_pass(4'(f), 4'(c))) begin
          bad++;
          $display("FAIL sweep f=%b c=%b got=%b want=%b",
                   4'(f), 4'(c), out_write, exp_pass(4'(f), 4'(c)));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(4'h9, 4'b1111, 4'b1110, 1'b1, 4'h4);
    drive(4'hA, 4'b0000, 4'b1110, 1'b0, 4'h5);
    total++;
    if (in_ready !== 1'b0 || flags !== 4'b1111) begin
      bad++;
      $display("FAIL midreset_pre got=rdy%b fl%b want=rdy0 fl1111",
               in_ready, flags);
    end
    do_reset();
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || flags !== 4'b0000 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset got=v%b fl%b rdy%b want=v0 fl0000 rdy1",
               out_valid, flags, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(4'h1, 4'h0, 4'b1110, 1'b0, 4'h1);
    drive(4'h2, 4'h0, 4'b1110, 1'b0, 4'h2);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_full_ready got=%b want=0", in_ready);
    end
    in_valid  = 1'b1;
    in_result = 4'h3;
    in_flags  = 4'h0;
    in_cond   = 4'b1111;
    in_dest   = 4'h3;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_result !== 4'h1 || out_dest !== 4'h1) begin
      bad++;
      $display("FAIL bp_hold got=rdy%b r%h d%h want=rdy0 r1 d1",
               in_ready, out_result, out_dest);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_result !== 4'h2 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_pop1 got=v%b r%h rdy%b want=v1 r2 rdy1",
               out_valid, out_result, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_result !== 4'h3 || out_write !== 1'b0) begin
      bad++;
      $display("FAIL bp_third got=v%b r%h w%b want=v1 r3 w0",
               out_valid, out_result, out_write);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_empty got=%b want=0", out_valid);
    end
  endtask

`ifdef FLAG_COND_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(4'(i), 4'h0, 4'b1110, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) drive(4'(i), 4'h0, 4'b1111, 1'b0, 4'h0);
    total++;
    if (exec_count !== 16'd5 || squash_count !== 16'd3) begin
      bad++;
      $display("FAIL stats got=%0d/%0d want=5/3", exec_count, squash_count);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_cond  = 4'b1110;
    repeat (65536) @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (exec_count !== 16'hFFFF) begin
      bad++; $display("FAIL stats_sat got=%h want=ffff", exec_count);
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_result    = '0;
    in_flags     = '0;
    in_cond      = '0;
    in_set_flags = 1'b0;
    in_dest      = '0;
    out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_back_to_back();
    test_squash();
    test_sweep();
    test_mid_reset();
    test_backpressure();
`ifdef FLAG_COND_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
